// File: rtl/execute_flush_ctrl.sv
// -----------------------------------------------------------------------------
// execute_flush_ctrl
//
// Sequencer for the execute-stage flush/redirect path. It takes the flush
// decision for the instruction in EX and registers the redirect PC. It then
// offers that PC to fetch over a valid/ready handshake. The IF and ID stages
// stay squashed for the whole recovery window, and IF stays killed for
// DRAIN_CYC further cycles so that stale fetch responses are dropped.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   ex_vld          EX holds a valid instruction
//   inst_branch     EX instruction is a conditional branch
//   inst_jalr       EX instruction is JALR
//   flush_in        flush decision for the EX instruction
//   br_pred         prediction used at fetch (1 = predicted taken)
//   ex_pc           PC of the EX instruction
//   br_target       branch target (pc + imm)
//   jalr_target     rs1 + imm, raw (bit 0 not yet cleared)
//   fe_redir_vld    redirect request to fetch
//   fe_redir_rdy    fetch accepts the redirect
//   fe_redir_pc     redirect PC, stable while fe_redir_vld=1
//   kill_if         squash IF and any fetch response
//   kill_id         squash ID
//   busy            controller not IDLE
//   cnt_flush       accepted flushes, all causes (wrapping)
//   cnt_mispred     accepted flushes caused by conditional branches (wrapping)
//   dbg_state       current FSM state (0 IDLE, 1 REDIR, 2 DRAIN)
//
// Handshake: a redirect is transferred on any rising edge where
// fe_redir_vld=1 and fe_redir_rdy=1. Once fe_redir_vld rises it stays high,
// with fe_redir_pc unchanged, until that edge. fe_redir_rdy may do anything
// while fe_redir_vld=0.
// -----------------------------------------------------------------------------
module execute_flush_ctrl #(
  parameter int ADDR_W    = 32,
  parameter int DRAIN_CYC = 2,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_vld,
  input  logic              inst_branch,
  input  logic              inst_jalr,
  input  logic              flush_in,
  input  logic              br_pred,
  input  logic [ADDR_W-1:0] ex_pc,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [ADDR_W-1:0] jalr_target,
  output logic              fe_redir_vld,
  input  logic              fe_redir_rdy,
  output logic [ADDR_W-1:0] fe_redir_pc,
  output logic              kill_if,
  output logic              kill_id,
  output logic              busy,
  output logic [CNT_W-1:0]  cnt_flush,
  output logic [CNT_W-1:0]  cnt_mispred,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REDIR = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [3:0]        DRAIN_LOAD = 4'(DRAIN_CYC);
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] LSB_MASK   = ~ADDR_W'(1);

  state_t            state_q, state_d;
  logic [3:0]        drain_q, drain_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_flush_q, cnt_mispred_q;
  logic [ADDR_W-1:0] redir_sel;
  logic              acc;

  // Redirect target selection. JALR wins over branch when both type bits are
  // set. A branch predicted taken that reaches a flush was actually not
  // taken, so it resumes at the fall-through PC.
  always_comb begin
    redir_sel = br_target;
    if (inst_jalr) begin
      redir_sel = jalr_target & LSB_MASK;
    end else if (br_pred) begin
      redir_sel = ex_pc + PC_STEP;
    end
  end

  // Next-state logic. acc is only possible in IDLE, so flush inputs seen
  // during REDIR/DRAIN are ignored. It is gated by rst_n so that the
  // combinational kills read 0 while reset is asserted.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    pc_d    = pc_q;
    acc     = 1'b0;
    case (state_q)
      IDLE: begin
        acc = rst_n & ex_vld & flush_in & (inst_branch | inst_jalr);
        if (acc) begin
          state_d = REDIR;
          pc_d    = redir_sel;
        end
      end
      REDIR: begin
        if (fe_redir_rdy) begin
          if (DRAIN_CYC == 0) begin
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
            drain_d = DRAIN_LOAD;
          end
        end
      end
      DRAIN: begin
        // Counter holds the number of DRAIN cycles still to run, including
        // this one. Leave when it reads 1.
        if (drain_q <= 4'd1) begin
          state_d = IDLE;
          drain_d = 4'd0;
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        drain_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      drain_q <= 4'd0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      pc_q    <= pc_d;
    end
  end

  // Event counters wrap freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_flush_q   <= '0;
      cnt_mispred_q <= '0;
    end else if (acc) begin
      cnt_flush_q <= cnt_flush_q + CNT_W'(1);
      if (!inst_jalr) begin
        cnt_mispred_q <= cnt_mispred_q + CNT_W'(1);
      end
    end
  end

  assign fe_redir_vld = (state_q == REDIR);
  assign fe_redir_pc  = pc_q;
  assign kill_if      = acc | (state_q != IDLE);
  assign kill_id      = acc | (state_q == REDIR);
  assign busy         = (state_q != IDLE);
  assign cnt_flush    = cnt_flush_q;
  assign cnt_mispred  = cnt_mispred_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_execute_flush_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for execute_flush_ctrl. Two instances share one set of inputs:
//   dut_a: DRAIN_CYC=2, CNT_W=32
//   dut_b: DRAIN_CYC=0, CNT_W=4  (zero-drain build, counters wrap at 16)
// The reference model describes each instance by plain facts: whether a
// redirect is outstanding, its PC, how many kill cycles remain after the
// handshake, and the event totals. Redirect PCs go through an expected
// queue per instance and are popped when the handshake is seen.
// -----------------------------------------------------------------------------
module tb_execute_flush_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- shared inputs ----------------
  logic        ex_vld, inst_branch, inst_jalr, flush_in, br_pred, fe_redir_rdy;
  logic [31:0] ex_pc, br_target, jalr_target;

  // ---------------- outputs ----------------
  logic [1:0]  o_vld, o_kif, o_kid, o_busy;
  logic [31:0] o_pc [2];
  logic [1:0]  o_st [2];
  logic [31:0] a_fl, a_mp;
  logic [3:0]  b_fl, b_mp;

  execute_flush_ctrl #(.ADDR_W(32), .DRAIN_CYC(2), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .ex_vld(ex_vld), .inst_branch(inst_branch),
    .inst_jalr(inst_jalr), .flush_in(flush_in), .br_pred(br_pred),
    .ex_pc(ex_pc), .br_target(br_target), .jalr_target(jalr_target),
    .fe_redir_vld(o_vld[0]), .fe_redir_rdy(fe_redir_rdy), .fe_redir_pc(o_pc[0]),
    .kill_if(o_kif[0]), .kill_id(o_kid[0]), .busy(o_busy[0]),
    .cnt_flush(a_fl), .cnt_mispred(a_mp), .dbg_state(o_st[0])
  );

  execute_flush_ctrl #(.ADDR_W(32), .DRAIN_CYC(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .ex_vld(ex_vld), .inst_branch(inst_branch),
    .inst_jalr(inst_jalr), .flush_in(flush_in), .br_pred(br_pred),
    .ex_pc(ex_pc), .br_target(br_target), .jalr_target(jalr_target),
    .fe_redir_vld(o_vld[1]), .fe_redir_rdy(fe_redir_rdy), .fe_redir_pc(o_pc[1]),
    .kill_if(o_kif[1]), .kill_id(o_kid[1]), .busy(o_busy[1]),
    .cnt_flush(b_fl), .cnt_mispred(b_mp), .dbg_state(o_st[1])
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q_a[$];
  logic [31:0] exp_q_b[$];

  bit          m_pend  [2];
  logic [31:0] m_pc    [2];
  int          m_drain [2];
  logic [31:0] m_fl    [2];
  logic [31:0] m_mp    [2];
  int          n_drain [2] = '{2, 0};
  logic [31:0] cmask   [2] = '{32'hFFFF_FFFF, 32'h0000_000F};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=0x%08h expected=0x%08h @%0t", tag, got, exp, $time);
  endtask

  function automatic logic [31:0] target_of();
    if (inst_jalr)    return jalr_target & 32'hFFFF_FFFE;
    else if (br_pred) return ex_pc + 32'd4;
    else              return br_target;
  endfunction

  function automatic bit model_busy(int i);
    return m_pend[i] || (m_drain[i] > 0);
  endfunction

  function automatic bit model_acc(int i);
    return rst_n && !model_busy(i) && ex_vld && flush_in && (inst_branch || inst_jalr);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_pc[i] = '0; m_drain[i] = 0; m_fl[i] = '0; m_mp[i] = '0;
    end
    exp_q_a.delete();
    exp_q_b.delete();
  endtask

  task automatic check_dut(int i);
    logic [31:0] fl, mp;
    bit b, a;
    b  = model_busy(i);
    a  = model_acc(i);
    fl = (i == 0) ? a_fl : {28'd0, b_fl};
    mp = (i == 0) ? a_mp : {28'd0, b_mp};
    check($sformatf("kill_if%0d", i), {31'd0, o_kif[i]}, {31'd0, a || b});
    check($sformatf("kill_id%0d", i), {31'd0, o_kid[i]}, {31'd0, a || m_pend[i]});
    check($sformatf("busy%0d", i),    {31'd0, o_busy[i]}, {31'd0, b});
    check($sformatf("vld%0d", i),     {31'd0, o_vld[i]}, {31'd0, m_pend[i]});
    if (m_pend[i]) check($sformatf("pc%0d", i), o_pc[i], m_pc[i]);
    check($sformatf("cnt_flush%0d", i), fl, m_fl[i]);
    check($sformatf("cnt_mispred%0d", i), mp, m_mp[i]);
  endtask

  task automatic update_model(int i);
    logic [31:0] e;
    if (model_acc(i)) begin
      m_pend[i] = 1;
      m_pc[i]   = target_of();
      if (i == 0) exp_q_a.push_back(m_pc[i]); else exp_q_b.push_back(m_pc[i]);
      m_fl[i] = (m_fl[i] + 1) & cmask[i];
      if (!inst_jalr) m_mp[i] = (m_mp[i] + 1) & cmask[i];
    end else if (m_pend[i] && fe_redir_rdy) begin
      e = (i == 0) ? exp_q_a.pop_front() : exp_q_b.pop_front();
      check($sformatf("handshake_pc%0d", i), o_pc[i], e);
      m_pend[i]  = 0;
      m_drain[i] = n_drain[i];
    end else if (m_drain[i] > 0) begin
      m_drain[i]--;
    end
  endtask

  // One cycle: inputs already driven after a falling edge.
  task automatic step();
    #1;
    for (int i = 0; i < 2; i++) begin
      check_dut(i);
      update_model(i);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    ex_vld = 0; inst_branch = 0; inst_jalr = 0; flush_in = 0; br_pred = 0;
    ex_pc = '0; br_target = '0; jalr_target = '0;
  endtask

  task automatic set_flush(input bit br, input bit jr, input bit pred,
                           input logic [31:0] pc, input logic [31:0] bt,
                           input logic [31:0] jt);
    ex_vld = 1; flush_in = 1; inst_branch = br; inst_jalr = jr; br_pred = pred;
    ex_pc = pc; br_target = bt; jalr_target = jt;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, "_vld"},  {31'd0, o_vld[i]},  32'd0);
      check({tag, "_kif"},  {31'd0, o_kif[i]},  32'd0);
      check({tag, "_kid"},  {31'd0, o_kid[i]},  32'd0);
      check({tag, "_busy"}, {31'd0, o_busy[i]}, 32'd0);
      check({tag, "_pc"},   o_pc[i],            32'd0);
    end
    check({tag, "_afl"}, a_fl, 32'd0);
    check({tag, "_amp"}, a_mp, 32'd0);
    check({tag, "_bfl"}, {28'd0, b_fl}, 32'd0);
    check({tag, "_bmp"}, {28'd0, b_mp}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 0;
    set_idle();
    fe_redir_rdy = 1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1;
    @(negedge clk);

    // Taken-mispredict: redirect to br_target, N=2 drain on dut_a.
    set_flush(1, 0, 0, 32'h0000_0800, 32'h0000_1000, 32'h0);
    #1;
    check("tk_kill_if", {31'd0, o_kif[0]}, 32'd1);
    check("tk_kill_id", {31'd0, o_kid[0]}, 32'd1);
    step();                                   // T
    set_idle();
    check("tk_vld", {31'd0, o_vld[0]}, 32'd1);
    check("tk_pc", o_pc[0], 32'h0000_1000);
    check("tk_fl", a_fl, 32'd1);
    check("tk_mp", a_mp, 32'd1);
    step();                                   // T+1, handshake
    check("tk_b_idle_h1", {31'd0, o_busy[1]}, 32'd0);
    check("tk_a_drain_kid", {31'd0, o_kid[0]}, 32'd0);
    check("tk_a_drain_kif", {31'd0, o_kif[0]}, 32'd1);
    step();                                   // T+2
    step();                                   // T+3
    check("tk_a_idle_t4", {31'd0, o_busy[0]}, 32'd0);

    // Not-taken-mispredict with PC wrap.
    set_flush(1, 0, 1, 32'hFFFF_FFFC, 32'h1234_5678, 32'h0);
    step();
    set_idle();
    check("nt_pc_wrap", o_pc[0], 32'h0000_0000);
    check("nt_vld", {31'd0, o_vld[0]}, 32'd1);
    repeat (3) step();

    // JALR with inst_branch also set: JALR wins, bit 0 cleared.
    set_flush(1, 1, 0, 32'h0000_0100, 32'h0000_0abc, 32'h0000_2003);
    step();
    set_idle();
    check("jalr_pc", o_pc[0], 32'h0000_2002);
    check("jalr_fl", a_fl, 32'd3);
    check("jalr_mp", a_mp, 32'd2);
    repeat (3) step();

    // Backpressure with spurious flushes during REDIR and DRAIN.
    set_flush(1, 0, 0, 32'h0000_0010, 32'h0000_3000, 32'h0);
    step();
    fe_redir_rdy = 0;
    for (int k = 0; k < 5; k++) begin
      flush_in = k[0];
      br_target = $urandom;
      check("bp_vld", {31'd0, o_vld[0]}, 32'd1);
      check("bp_pc", o_pc[0], 32'h0000_3000);
      step();
    end
    fe_redir_rdy = 1;
    flush_in = 1;
    step();                                   // handshake
    step();                                   // DRAIN
    step();                                   // DRAIN
    set_idle();
    check("bp_fl", a_fl, 32'd4);
    check("bp_mp", a_mp, 32'd3);
    step();

    // Asynchronous reset while dut_a is in REDIR.
    set_flush(0, 1, 0, 32'h0, 32'h0, 32'h0000_4444);
    step();
    set_idle();
    fe_redir_rdy = 0;
    check("rst_pre_vld", {31'd0, o_vld[0]}, 32'd1);
    #2 rst_n = 0;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1;
    fe_redir_rdy = 1;
    step();

    // Counter wrap on the 4-bit build: 16 flushes bring cnt_flush back to 0.
    for (int k = 0; k < 16; k++) begin
      set_flush(1, 0, 0, 32'h0, 32'($urandom) & 32'hFFFF_FFFC, 32'h0);
      step();
      set_idle();
      repeat (3) step();
    end
    check("wrap_b_fl", {28'd0, b_fl}, 32'd0);
    check("wrap_b_mp", {28'd0, b_mp}, 32'd0);
    check("wrap_a_fl", a_fl, 32'd16);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      ex_vld       = ($urandom_range(0, 3) != 0);
      flush_in     = ($urandom_range(0, 2) == 0);
      inst_branch  = $urandom_range(0, 1);
      inst_jalr    = ($urandom_range(0, 3) == 0);
      br_pred      = $urandom_range(0, 1);
      ex_pc        = $urandom;
      br_target    = $urandom;
      jalr_target  = $urandom;
      fe_redir_rdy = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
